// File: rtl/opfetch_pkg.sv
// Shared encodings for the operand fetch unit: source selects and FSM states.
package opfetch_pkg;

  localparam logic [2:0] SRC_A    = 3'd0;
  localparam logic [2:0] SRC_B    = 3'd1;
  localparam logic [2:0] SRC_K    = 3'd2;
  localparam logic [2:0] SRC_ZERO = 3'd3;
  localparam logic [2:0] SRC_MEM  = 3'd4;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CAPTURE  = 2'd1;
  localparam logic [1:0] ST_WAIT_MEM = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  function automatic logic is_mem(input logic [2:0] sel);
    return sel == SRC_MEM;
  endfunction

endpackage

// File: rtl/operand_sel.sv
// Combinational 5:1 operand source select; unused encodings and masked K give zero.
module operand_sel
  import opfetch_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter bit          ALLOW_K = 1'b1
) (
  input  logic [2:0]   i_sel,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_k,
  input  logic [W-1:0] i_mem,
  output logic [W-1:0] o_op_c
);

  always_comb begin
    o_op_c = '0;
    case (i_sel)
      SRC_A:   o_op_c = i_a;
      SRC_B:   o_op_c = i_b;
      SRC_K:   o_op_c = ALLOW_K ? i_k : '0;
      SRC_MEM: o_op_c = i_mem;
      default: o_op_c = '0;
    endcase
  end

endmodule

// File: rtl/operand_fetch_unit.sv
// ALU operand fetch: captures sources on start, optionally reads memory with a
// timeout, and presents a registered operand pair over a valid/ready handshake.
module operand_fetch_unit
  import opfetch_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned TIMEOUT   = 16,
  parameter bit          ALLOW_K_A = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   sel_a,
  input  logic [2:0]   sel_b,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [W-1:0] K,
  output logic         mem_req,
  input  logic         mem_valid,
  input  logic [W-1:0] mem_data,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic         op_valid,
  input  logic         op_ready,
  output logic         busy,
  output logic         err
);

  localparam int unsigned CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_LIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       r_state, w_state_nxt;
  logic [2:0]       r_sel_a, w_sel_a_nxt;
  logic [2:0]       r_sel_b, w_sel_b_nxt;
  logic [W-1:0]     r_a, w_a_nxt;
  logic [W-1:0]     r_b, w_b_nxt;
  logic [W-1:0]     r_k, w_k_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [W-1:0]     r_op_a, w_op_a_nxt;
  logic [W-1:0]     r_op_b, w_op_b_nxt;
  logic             r_op_valid, w_op_valid_nxt;
  logic             r_mem_req, w_mem_req_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_err, w_err_nxt;

  logic [W-1:0]     w_mem_data;
  logic [W-1:0]     w_sel_a_op;
  logic [W-1:0]     w_sel_b_op;
  logic             w_timeout;

  // Memory contributes only on a valid beat; a timeout therefore yields zero for MEM operands.
  assign w_mem_data = (r_state == ST_WAIT_MEM && mem_valid) ? mem_data : '0;
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt == CNT_W'(CNT_LIM));

  operand_sel #(.W(W), .ALLOW_K(ALLOW_K_A)) u_sel_a (
    .i_sel (r_sel_a),
    .i_a   (r_a),
    .i_b   (r_b),
    .i_k   (r_k),
    .i_mem (w_mem_data),
    .o_op_c(w_sel_a_op)
  );

  operand_sel #(.W(W), .ALLOW_K(1'b1)) u_sel_b (
    .i_sel (r_sel_b),
    .i_a   (r_a),
    .i_b   (r_b),
    .i_k   (r_k),
    .i_mem (w_mem_data),
    .o_op_c(w_sel_b_op)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_sel_a_nxt    = r_sel_a;
    w_sel_b_nxt    = r_sel_b;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_k_nxt        = r_k;
    w_cnt_nxt      = r_cnt;
    w_op_a_nxt     = r_op_a;
    w_op_b_nxt     = r_op_b;
    w_op_valid_nxt = r_op_valid;
    w_mem_req_nxt  = r_mem_req;
    w_err_nxt      = r_err;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_sel_a_nxt = sel_a;
          w_sel_b_nxt = sel_b;
          w_a_nxt     = A;
          w_b_nxt     = B;
          w_k_nxt     = K;
          w_err_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (is_mem(r_sel_a) || is_mem(r_sel_b)) begin
          w_mem_req_nxt = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_WAIT_MEM;
        end else begin
          w_op_a_nxt     = w_sel_a_op;
          w_op_b_nxt     = w_sel_b_op;
          w_op_valid_nxt = 1'b1;
          w_state_nxt    = ST_DONE;
        end
      end
      ST_WAIT_MEM: begin
        // A data beat on the limit cycle still wins over the timeout.
        if (mem_valid || w_timeout) begin
          w_op_a_nxt     = w_sel_a_op;
          w_op_b_nxt     = w_sel_b_op;
          w_err_nxt      = !mem_valid;
          w_mem_req_nxt  = 1'b0;
          w_op_valid_nxt = 1'b1;
          w_state_nxt    = ST_DONE;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (op_ready) begin
          w_op_valid_nxt = 1'b0;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sel_a    <= '0;
      r_sel_b    <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_k        <= '0;
      r_cnt      <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_valid <= 1'b0;
      r_mem_req  <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel_a    <= w_sel_a_nxt;
      r_sel_b    <= w_sel_b_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_k        <= w_k_nxt;
      r_cnt      <= w_cnt_nxt;
      r_op_a     <= w_op_a_nxt;
      r_op_b     <= w_op_b_nxt;
      r_op_valid <= w_op_valid_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_busy     <= w_busy_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign mem_req  = r_mem_req;
  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign op_valid = r_op_valid;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Scoreboard bench for operand_fetch_unit: a driver queues expected operand
// pairs, a monitor pops and compares them on every ALU transfer.
module tb_operand_fetch_unit;

  localparam int unsigned W       = 8;
  localparam int unsigned TIMEOUT = 16;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   sel_a, sel_b;
  logic [W-1:0] A, B, K;
  logic         mem_req;
  logic         mem_valid;
  logic [W-1:0] mem_data;
  logic [W-1:0] op_a, op_b;
  logic         op_valid;
  logic         op_ready;
  logic         busy;
  logic         err;

  int   vectors     = 0;
  int   miscompares = 0;
  int   bursts      = 0;
  logic mreq_q      = 1'b0;
  exp_t sb_q[$];

  operand_fetch_unit #(.W(W), .TIMEOUT(TIMEOUT), .ALLOW_K_A(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sel_a    (sel_a),
    .sel_b    (sel_b),
    .A        (A),
    .B        (B),
    .K        (K),
    .mem_req  (mem_req),
    .mem_valid(mem_valid),
    .mem_data (mem_data),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && op_valid && op_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_op_a", 32'(op_a), 32'(e.a));
        check("sb_op_b", 32'(op_b), 32'(e.b));
        check("sb_err", 32'(err), 32'(e.e));
      end
    end
    if (mem_req && !mreq_q) bursts++;
    mreq_q = mem_req;
  end

  // One transaction; mem_delay < 0 means memory never answers.
  task automatic do_fetch(input logic [2:0] sa, input logic [2:0] sb,
                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] k,
                          input int mem_delay, input logic [7:0] md, input int hold,
                          input bit poke, input logic [7:0] ea, input logic [7:0] eb,
                          input logic ee);
    int n;
    bit uses_mem;
    uses_mem = (sa == 3'd4) || (sb == 3'd4);
    sb_q.push_back('{a: ea, b: eb, e: ee});
    check("idle_before_start", 32'(busy), 32'd0);
    sel_a = sa; sel_b = sb; A = a; B = b; K = k; start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    if (poke) begin
      start = 1'b1; A = ~a; B = ~b; K = ~k; sel_a = 3'd1; sel_b = 3'd1;
    end
    if (uses_mem) begin
      int w;
      w = 0;
      while (!mem_req && w < 50) begin step(); w++; end
      if (w >= 50) check("mem_req_wait", 32'd0, 32'd1);
      if (mem_delay >= 0) begin
        repeat (mem_delay) step();
        mem_valid = 1'b1; mem_data = md;
        step();
        mem_valid = 1'b0; mem_data = 8'h00;
        check("valid_after_mem", 32'(op_valid), 32'd1);
        check("mem_req_dropped", 32'(mem_req), 32'd0);
      end else begin
        int t;
        t = 0;
        while (!op_valid && t < 100) begin step(); t++; end
        check("timeout_cycles", 32'(t), 32'(TIMEOUT));
        check("mem_req_after_to", 32'(mem_req), 32'd0);
      end
    end else begin
      while (!op_valid && n < 50) begin step(); n++; end
      check("latency_nomem", 32'(n), 32'd2);
    end
    for (int i = 0; i < hold; i++) begin
      check("hold_op_a", 32'(op_a), 32'(ea));
      check("hold_op_b", 32'(op_b), 32'(eb));
      check("hold_valid", 32'(op_valid), 32'd1);
      check("hold_busy", 32'(busy), 32'd1);
      step();
    end
    start = 1'b0;
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    check("valid_after_xfer", 32'(op_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    rst_n = 1'b0; start = 1'b0; sel_a = 3'd0; sel_b = 3'd0;
    A = '0; B = '0; K = '0; mem_valid = 1'b0; mem_data = '0; op_ready = 1'b0;
    repeat (2) step();
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ops", 32'({op_a, op_b}), 32'd0);
    rst_n = 1'b1;
    step();

    // A and K, held off by the ALU for three cycles
    do_fetch(3'd0, 3'd2, 8'h3C, 8'h00, 8'h05, 0, 8'h00, 3, 1'b0, 8'h3C, 8'h05, 1'b0);

    // both operands from one memory read
    b0 = bursts;
    do_fetch(3'd4, 3'd4, 8'h01, 8'h02, 8'h03, 4, 8'hA7, 1, 1'b0, 8'hA7, 8'hA7, 1'b0);
    check("single_burst", 32'(bursts - b0), 32'd1);

    // reset in the middle of a memory wait, with a coincident data beat
    sel_a = 3'd4; sel_b = 3'd0; A = 8'h55; start = 1'b1;
    step();
    start = 1'b0;
    for (int w = 0; w < 50 && !mem_req; w++) step();
    check("pre_reset_req", 32'(mem_req), 32'd1);
    mem_valid = 1'b1; mem_data = 8'hEE;
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ops", 32'({op_a, op_b, op_valid, err}), 32'd0);
    step();
    mem_valid = 1'b0; mem_data = 8'h00;
    rst_n = 1'b1;
    step();
    check("post_rst_idle", 32'({busy, op_valid, mem_req}), 32'd0);

    // memory never answers: timeout zeroes the MEM operand and flags err
    do_fetch(3'd1, 3'd4, 8'h12, 8'h34, 8'h56, -1, 8'h00, 1, 1'b0, 8'h34, 8'h00, 1'b1);

    // K masked on side a; err cleared by this start
    do_fetch(3'd2, 3'd3, 8'hAA, 8'hBB, 8'hFF, 0, 8'h00, 0, 1'b0, 8'h00, 8'h00, 1'b0);
    do_fetch(3'd7, 3'd5, 8'hAA, 8'hBB, 8'hFF, 0, 8'h00, 0, 1'b0, 8'h00, 8'h00, 1'b0);
    do_fetch(3'd3, 3'd1, 8'hAA, 8'h5A, 8'hFF, 0, 8'h00, 0, 1'b0, 8'h00, 8'h5A, 1'b0);
    // K is legal on side b
    do_fetch(3'd1, 3'd2, 8'h00, 8'h66, 8'h9D, 0, 8'h00, 1, 1'b0, 8'h66, 8'h9D, 1'b0);

    // start while busy and source changes after capture are ignored
    do_fetch(3'd0, 3'd4, 8'h11, 8'h22, 8'h33, 0, 8'hC3, 2, 1'b1, 8'h11, 8'hC3, 1'b0);
    do_fetch(3'd4, 3'd0, 8'h77, 8'h00, 8'h00, 2, 8'h0F, 0, 1'b1, 8'h0F, 8'h77, 1'b0);

    repeat (3) step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("final_idle", 32'({busy, op_valid, mem_req}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
